fp_stream_minmax: RTL and testbench
===================================

Name: fp_stream_minmax

Overview:
- Streaming reduction stage that sits downstream of the single-precision comparator path.
- Accepts a frame of IEEE-754 single-precision samples over a valid/ready handshake and tracks the running minimum and maximum, one sample per cycle.
- Presents min, max, sample count and a NaN flag for the frame over an output valid/ready handshake.
- Ordering rules are identical to the team's FP comparator, so results agree bit-for-bit with comparator-based checks.

Parameters:
- CNT_W, 16, width of the per-frame accepted-sample counter; the counter saturates at all-ones.
- NAN_OUT, 32'h7FC00000, value driven on out_min and out_max when a frame contains no non-NaN sample.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data and in_last are valid
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  32  IEEE-754 single-precision sample
- in_last  input  1  the accompanying sample is the final sample of the frame
- out_valid  output  1  frame result is valid
- out_ready  input  1  downstream accepts the result
- out_min  output  32  smallest non-NaN sample in the frame
- out_max  output  32  largest non-NaN sample in the frame
- out_count  output  CNT_W  number of samples accepted in the frame, NaNs included, saturating
- out_nan_seen  output  1  at least one NaN was accepted in the frame

Behaviour:
- Reset (async assert, sync deassert on clk):
  - state=ACCUM; in_ready=1; out_valid=0.
  - out_min=out_max=0; out_count=0; out_nan_seen=0.
  - Internal have_value=0.
- Transfer rules:
  - An input transfer occurs when in_valid&&in_ready on a rising edge.
  - An output transfer occurs when out_valid&&out_ready on a rising edge.
- Ordering (total, sign-magnitude):
  - Signs differ: the sign=0 operand is greater, so -0.0 (80000000) < +0.0 (00000000).
  - Signs equal, magnitudes [30:0] equal: the operands are equal.
  - Both positive: the larger [30:0] is greater.
  - Both negative: the larger [30:0] is lesser.
- NaN: exponent=8'hFF and mantissa!=0. A NaN is counted and sets the nan flag, but never updates min or max. Infinities are ordinary values.
- State ACCUM (in_ready=1):
  - On each input transfer, count saturates at {CNT_W{1'b1}}.
  - Non-NaN sample with have_value=0: min=max=sample, and have_value is set.
  - Non-NaN sample with have_value=1: min is replaced only if sample < min; max is replaced only if sample > max. Equal samples leave the registers unchanged.
  - Transfer with in_last=1: on the same edge, latch the results into the out_* registers (including this sample), set out_valid=1, go to HOLD, and clear the accumulators (count, have_value, nan flag).
  - If have_value=0 at latch time, including the updated value from the last sample, out_min=out_max=NAN_OUT.
- State HOLD (in_ready=0, out_valid=1):
  - out_* registers are stable until the output transfer.
  - On the output transfer: out_valid=0, go to ACCUM, and in_ready=1 in the next cycle.
  - No input is accepted in the transfer cycle itself, so there is one bubble cycle per frame.
- Latency: the result is visible the cycle after the in_last transfer.
- Throughput: 1 sample/cycle within a frame.
- in_valid=0 cycles inside a frame are allowed and hold all state.
- A single-sample frame (first sample has in_last=1) is valid: min=max=sample, count=1.
- Reset mid-frame or in HOLD discards all state and any pending result.
- out_count saturation affects only the count; min and max keep updating.

Test Plan:
- Frame 3F800000, C0000000, 40400000(last) -> out_min=C0000000, out_max=40400000, count=3, nan_seen=0, out_valid one cycle after last.
- Frame 80000000, 00000000(last) -> out_min=80000000, out_max=00000000.
- Frame 7FC00001, FF800000, 7F800000, 7FA00000(last) -> min=FF800000, max=7F800000, count=4, nan_seen=1.
- Frame 7FC00000(last) -> min=max=7FC00000, count=1, nan_seen=1.
- Two back-to-back frames, out_ready held low 5 cycles:
  - in_ready stays 0 and the first result stays stable throughout.
  - After out_ready rises, one bubble, then the second frame result is correct and independent of the first.
- CNT_W=4, 20-sample frame of increasing 1.0..20.0 -> count=4'hF, max=41A00000 (20.0), min=3F800000.
- rst_n pulsed low mid-frame after two samples -> all outputs return to reset values asynchronously; the next frame's result excludes the earlier samples.

Source files
------------

// File: rtl/fp_stream_minmax.sv
// Streaming min/max reduction over frames of IEEE-754 single-precision samples.
// Ordering matches the team FP comparator: total sign-magnitude order in which
// -0.0 < +0.0 and infinities are ordinary values; NaNs are counted but never
// become min or max.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds data stable while valid is high and ready is low; ready never
// depends combinationally on valid on either port (both are pure state decodes).
module fp_stream_minmax #(
  parameter int          CNT_W   = 16,
  parameter logic [31:0] NAN_OUT = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_min,
  output logic [31:0]      out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan_seen,
  output logic [0:0]       dbg_state
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // a < b in the comparator's total order
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    logic res;
    if (a[31] != b[31])  res = a[31];
    else if (!a[31])     res = (a[30:0] < b[30:0]);
    else                 res = (a[30:0] > b[30:0]);
    return res;
  endfunction

  logic [1:0]       rst_sync_q;
  logic             rst_int_n;
  logic [0:0]       state_q, state_d;
  logic [31:0]      min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             have_q, have_d, nan_q, nan_d;
  logic [31:0]      out_min_q, out_min_d, out_max_q, out_max_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_nan_q, out_nan_d;
  logic             in_xfer, out_xfer, is_nan;
  logic [31:0]      min_n, max_n;
  logic [CNT_W-1:0] cnt_n;
  logic             have_n, nan_n;

  // Reset asserts asynchronously and releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1] & rst_n;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign is_nan    = (&in_data[30:23]) && (|in_data[22:0]);

  // Accumulator values including the sample currently offered
  always_comb begin
    min_n  = min_q;
    max_n  = max_q;
    cnt_n  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    have_n = have_q | ~is_nan;
    nan_n  = nan_q | is_nan;
    if (!is_nan) begin
      if (!have_q) begin
        min_n = in_data;
        max_n = in_data;
      end else begin
        if (fp_lt(in_data, min_q)) min_n = in_data;
        if (fp_lt(max_q, in_data)) max_n = in_data;
      end
    end
  end

  // FSM and register next-state: accumulate, latch on last, hold until taken
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    have_d    = have_q;
    nan_d     = nan_q;
    out_min_d = out_min_q;
    out_max_d = out_max_q;
    out_cnt_d = out_cnt_q;
    out_nan_d = out_nan_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_xfer) begin
          if (in_last) begin
            out_min_d = have_n ? min_n : NAN_OUT;
            out_max_d = have_n ? max_n : NAN_OUT;
            out_cnt_d = cnt_n;
            out_nan_d = nan_n;
            cnt_d     = '0;
            have_d    = 1'b0;
            nan_d     = 1'b0;
            state_d   = ST_HOLD;
          end else begin
            min_d  = min_n;
            max_d  = max_n;
            cnt_d  = cnt_n;
            have_d = have_n;
            nan_d  = nan_n;
          end
        end
      end
      default: begin
        if (out_xfer) state_d = ST_ACCUM;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_ACCUM;
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      have_q    <= 1'b0;
      nan_q     <= 1'b0;
      out_min_q <= '0;
      out_max_q <= '0;
      out_cnt_q <= '0;
      out_nan_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      have_q    <= have_d;
      nan_q     <= nan_d;
      out_min_q <= out_min_d;
      out_max_q <= out_max_d;
      out_cnt_q <= out_cnt_d;
      out_nan_q <= out_nan_d;
    end
  end

  assign out_min      = out_min_q;
  assign out_max      = out_max_q;
  assign out_count    = out_cnt_q;
  assign out_nan_seen = out_nan_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fp_stream_minmax.sv
// Directed bench for fp_stream_minmax: one default instance (CNT_W=16) and one
// narrow-counter instance (CNT_W=4) driven by the same input stream.
module tb_fp_stream_minmax;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_nan_seen;
  logic [31:0] out_min, out_max;
  logic [15:0] out_count;
  logic [0:0]  dbg_state;

  logic        b_in_ready, b_out_valid, b_out_nan_seen;
  logic [31:0] b_out_min, b_out_max;
  logic [3:0]  b_out_count;
  logic [0:0]  b_dbg_state;

  int errors = 0;
  int checks = 0;

  // clock/reset block
  always #5 clk = ~clk;

  fp_stream_minmax #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
    .out_count(out_count), .out_nan_seen(out_nan_seen), .dbg_state(dbg_state)
  );

  fp_stream_minmax #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_min(b_out_min), .out_max(b_out_max),
    .out_count(b_out_count), .out_nan_seen(b_out_nan_seen), .dbg_state(b_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one sample, waiting a bounded time for in_ready; returns at edge+1
  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                              input logic [15:0] cnt, input logic nan);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_min"},   out_min, mn);
    check({tag, "_max"},   out_max, mx);
    check({tag, "_count"}, {16'b0, out_count}, {16'b0, cnt});
    check({tag, "_nan"},   {31'b0, out_nan_seen}, {31'b0, nan});
  endtask

  // Exact single-precision encoding of a small positive integer
  function automatic logic [31:0] int_to_fp(input int v);
    int msb = 0;
    logic [31:0] vb = v;
    for (int i = 0; i < 31; i++) if (vb[i]) msb = i;
    return {1'b0, 8'(127 + msb), 23'((vb << (23 - msb)) & 32'h007F_FFFF)};
  endfunction

  initial begin
    // reset values
    #12;
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_min",       out_min, 32'h0);
    check("rst_max",       out_max, 32'h0);
    check("rst_count",     {16'b0, out_count}, 32'd0);
    check("rst_nan",       {31'b0, out_nan_seen}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // frame 1: 1.0, -2.0, 3.0 with an idle cycle inside the frame
    send(32'h3F800000, 1'b0);
    @(posedge clk); #1;
    send(32'hC0000000, 1'b0);
    check("f1_no_early_valid", {31'b0, out_valid}, 32'd0);
    send(32'h40400000, 1'b1);
    check_result("f1", 32'hC0000000, 32'h40400000, 16'd3, 1'b0);
    check("f1_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("f1_b_count", {28'b0, b_out_count}, 32'd3);
    take_result();
    check("f1_taken_valid", {31'b0, out_valid}, 32'd0);
    check("f1_taken_ready", {31'b0, in_ready}, 32'd1);

    // frame 2: signed zeros
    send(32'h80000000, 1'b0);
    send(32'h00000000, 1'b1);
    check_result("f2", 32'h80000000, 32'h00000000, 16'd2, 1'b0);
    take_result();

    // frame 3: NaNs and infinities
    send(32'h7FC00001, 1'b0);
    send(32'hFF800000, 1'b0);
    send(32'h7F800000, 1'b0);
    send(32'h7FA00000, 1'b1);
    check_result("f3", 32'hFF800000, 32'h7F800000, 16'd4, 1'b1);
    take_result();

    // frame 4: lone NaN
    send(32'h7FC00000, 1'b1);
    check_result("f4", 32'h7FC00000, 32'h7FC00000, 16'd1, 1'b1);
    take_result();

    // back-to-back frames with stalled output
    send(32'h40000000, 1'b0);
    send(32'hBF800000, 1'b1);
    check_result("bb_a", 32'hBF800000, 32'h40000000, 16'd2, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h3F000000;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bb_hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("bb_hold_min", out_min, 32'hBF800000);
      check("bb_hold_max", out_max, 32'h40000000);
    end
    take_result();
    check("bb_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("bb_bubble_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(32'h3E800000, 1'b1);
    check_result("bb_b", 32'h3E800000, 32'h3F000000, 16'd2, 1'b0);
    take_result();

    // count saturation on the narrow instance, 1.0 .. 20.0
    for (int i = 1; i <= 20; i++) send(int_to_fp(i), (i == 20));
    check_result("sat", 32'h3F800000, 32'h41A00000, 16'd20, 1'b0);
    check("sat_b_count", {28'b0, b_out_count}, 32'h0000000F);
    check("sat_b_max",   b_out_max, 32'h41A00000);
    check("sat_b_min",   b_out_min, 32'h3F800000);
    take_result();

    // reset mid-frame, asserted between clock edges
    send(32'hC2000000, 1'b0);
    send(32'h42000000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_min",       out_min, 32'h0);
    check("mrst_max",       out_max, 32'h0);
    check("mrst_count",     {16'b0, out_count}, 32'd0);
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_in_ready",  {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    check_result("post_rst", 32'h3F800000, 32'h40000000, 16'd2, 1'b0);
    take_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
